// File: rtl/program_store_if.sv
// Program store bus.
// Groups the program-loading handshake, the run-time controls from the
// execution controller, and the fetch/status outputs of program_store.
//   master : host/controller side (drives characters and run controls)
//   slave  : program_store side (drives opcode fetch and status)
// Signals:
//   char_valid, char_in[7:0], prog_end   program text input
//   reload, rewind, LdPC, PCDecInc       run-time controls
//   out[3:0], pc, prog_len               fetch port and program info
//   ready, overflow, pc_fault            status flags
interface program_store_if #(
  parameter int ADDR_W = 8
);
  logic              char_valid;
  logic [7:0]        char_in;
  logic              prog_end;
  logic              reload;
  logic              rewind;
  logic              LdPC;
  logic              PCDecInc;
  logic [3:0]        out;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] prog_len;
  logic              ready;
  logic              overflow;
  logic              pc_fault;

  modport master (
    output char_valid, char_in, prog_end, reload, rewind, LdPC, PCDecInc,
    input  out, pc, prog_len, ready, overflow, pc_fault
  );

  modport slave (
    input  char_valid, char_in, prog_end, reload, rewind, LdPC, PCDecInc,
    output out, pc, prog_len, ready, overflow, pc_fault
  );
endinterface

// File: rtl/program_store.sv
// Program store for the Brainfuck execution controller.
// Accepts ASCII program text, drops non-Brainfuck bytes, encodes the rest
// into 4-bit opcodes in a local memory and terminates the program with a
// stop opcode (4'hF). While running it owns the program counter and presents
// the opcode at pc on bus.out with zero-latency fetch.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset, returns to LOAD
//   bus    program_store_if.slave: character input, run controls,
//          opcode fetch (out), pc, prog_len, ready, overflow, pc_fault
module program_store #(
  parameter int ADDR_W = 8
) (
  input logic           clk,
  input logic           reset,
  program_store_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [3:0]        STOP = 4'hF;

  typedef enum logic [1:0] {LOAD, SEAL, RUN} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] prog_len_reg;
  logic              ready_reg;
  logic              overflow_reg;
  logic              pc_fault_reg;

  logic [3:0]        mem [DEPTH];

  logic [3:0]        char_op;
  logic              char_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_data;

  // Character decoder: anything that is not one of the eight commands is
  // flagged invalid and has no effect at all.
  always_comb begin
    char_ok = 1'b1;
    char_op = STOP;
    case (bus.char_in)
      8'h3C:   char_op = 4'h0; // <
      8'h3E:   char_op = 4'h1; // >
      8'h2B:   char_op = 4'h2; // +
      8'h2D:   char_op = 4'h3; // -
      8'h5B:   char_op = 4'h4; // [
      8'h5D:   char_op = 4'h5; // ]
      8'h2E:   char_op = 4'h6; // .
      8'h2C:   char_op = 4'h7; // ,
      default: char_ok = 1'b0;
    endcase
  end

  // Single write port. The last slot is kept free so the stop opcode always
  // fits; a reset cycle never writes so an abandoned load leaves no trace.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_ptr_reg;
    mem_data = char_op;
    if (!reset) begin
      case (state_reg)
        LOAD: mem_we = bus.char_valid && char_ok && (wr_ptr_reg != LAST);
        SEAL: begin
          mem_we   = 1'b1;
          mem_data = STOP;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= LOAD;
      wr_ptr_reg   <= '0;
      pc_reg       <= '0;
      prog_len_reg <= '0;
      ready_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      pc_fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          // A character arriving together with prog_end is stored first, so
          // SEAL sees the already-advanced wr_ptr.
          if (bus.char_valid && char_ok) begin
            if (wr_ptr_reg != LAST) begin
              wr_ptr_reg <= wr_ptr_reg + ONE;
            end else begin
              overflow_reg <= 1'b1;
            end
          end
          if (bus.prog_end) begin
            state_reg <= SEAL;
          end
        end
        SEAL: begin
          prog_len_reg <= wr_ptr_reg;
          pc_reg       <= '0;
          ready_reg    <= 1'b1;
          state_reg    <= RUN;
        end
        RUN: begin
          if (bus.reload) begin
            state_reg    <= LOAD;
            wr_ptr_reg   <= '0;
            pc_reg       <= '0;
            prog_len_reg <= '0;
            ready_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            pc_fault_reg <= 1'b0;
          end else if (bus.rewind) begin
            pc_reg <= '0;
          end else if (bus.LdPC) begin
            // No wrap-around: a step off either end holds pc and flags it.
            if (bus.PCDecInc) begin
              if (pc_reg == '0) pc_fault_reg <= 1'b1;
              else              pc_reg <= pc_reg - ONE;
            end else begin
              if (pc_reg == LAST) pc_fault_reg <= 1'b1;
              else                pc_reg <= pc_reg + ONE;
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  // Combinational fetch so the controller sees the new opcode in the same
  // cycle pc changes.
  assign bus.out      = ready_reg ? mem[pc_reg] : STOP;
  assign bus.pc       = pc_reg;
  assign bus.prog_len = prog_len_reg;
  assign bus.ready    = ready_reg;
  assign bus.overflow = overflow_reg;
  assign bus.pc_fault = pc_fault_reg;
endmodule

// File: tb/tb_program_store.sv
// Testbench for program_store (ADDR_W=3, 8 opcode slots).
// Directed steps followed by randomized programs and run sequences, all
// checked against a program-level reference model kept in the bench.
module tb_program_store;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_store_if #(.ADDR_W(AW)) bus ();

  program_store #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: program as a list of opcodes, memory image, run state.
  int         q[$];
  logic [3:0] mm[DEPTH];
  int         m_pc;
  int         m_len;
  bit         m_ready;
  bit         m_ovf;
  bit         m_fault;

  function automatic int enc(byte c);
    case (c)
      "<":     return 0;
      ">":     return 1;
      "+":     return 2;
      "-":     return 3;
      "[":     return 4;
      "]":     return 5;
      ".":     return 6;
      ",":     return 7;
      default: return -1;
    endcase
  endfunction

  function automatic void model_clear();
    q.delete();
    m_pc = 0; m_len = 0; m_ready = 0; m_ovf = 0; m_fault = 0;
  endfunction

  function automatic void model_char(byte c);
    int e;
    e = enc(c);
    if (e >= 0) begin
      if (q.size() < DEPTH - 1) q.push_back(e);
      else m_ovf = 1;
    end
  endfunction

  function automatic void model_seal();
    m_len = q.size();
    for (int i = 0; i < m_len; i++) mm[i] = 4'(q[i]);
    mm[m_len] = 4'hF;
    m_pc = 0;
    m_ready = 1;
  endfunction

  function automatic void model_step(bit dec);
    if (dec) begin
      if (m_pc == 0) m_fault = 1;
      else m_pc = m_pc - 1;
    end else begin
      if (m_pc == DEPTH - 1) m_fault = 1;
      else m_pc = m_pc + 1;
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(string tag);
    logic [3:0] exp_out;
    exp_out = m_ready ? mm[m_pc] : 4'hF;
    chk({tag, ".pc"},       32'(bus.pc),       32'(m_pc));
    chk({tag, ".prog_len"}, 32'(bus.prog_len), 32'(m_len));
    chk({tag, ".ready"},    32'(bus.ready),    32'(m_ready));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".pc_fault"}, 32'(bus.pc_fault), 32'(m_fault));
    chk({tag, ".out"},      32'(bus.out),      32'(exp_out));
    $display("[TB] %s pc=%0d len=%0d ready=%0b ovf=%0b fault=%0b out=%h",
             tag, bus.pc, bus.prog_len, bus.ready, bus.overflow, bus.pc_fault, bus.out);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.char_valid = 0; bus.char_in = 8'h00; bus.prog_end = 0;
    bus.reload = 0; bus.rewind = 0; bus.LdPC = 0; bus.PCDecInc = 0;
  endtask

  task automatic do_reset(string tag);
    reset = 1;
    tick();
    reset = 0;
    model_clear();
    check_state(tag);
  endtask

  // One LOAD cycle: optional character, optional prog_end; a prog_end is
  // followed by the SEAL cycle and a check of the running state.
  task automatic feed(string tag, byte c, bit v, bit e);
    bus.char_valid = v; bus.char_in = c; bus.prog_end = e;
    tick();
    idle();
    if (v) model_char(c);
    check_state(tag);
    if (e) begin
      tick();
      model_seal();
      check_state({tag, ".seal"});
    end
  endtask

  task automatic load_str(string tag, string s, bit end_with_last);
    for (int i = 0; i < s.len(); i++)
      feed(tag, s[i], 1'b1, end_with_last && (i == s.len() - 1));
    if (!end_with_last || s.len() == 0) feed(tag, 8'h00, 1'b0, 1'b1);
  endtask

  // One RUN cycle with the given controls; junk drives loading inputs that
  // must be ignored while running.
  task automatic run_op(string tag, bit ld, bit dec, bit rw, bit rl, bit junk);
    bus.LdPC = ld; bus.PCDecInc = dec; bus.rewind = rw; bus.reload = rl;
    bus.char_valid = junk; bus.char_in = "+"; bus.prog_end = junk;
    tick();
    idle();
    if (rl) model_clear();
    else if (rw) m_pc = 0;
    else if (ld) model_step(dec);
    check_state(tag);
  endtask

  // Walk the whole memory from 0 upward, checking every fetched opcode.
  task automatic walk(string tag);
    run_op({tag, ".rewind"}, 0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) run_op({tag, ".inc"}, 1, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string al;
    string s;
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    model_clear();
    check_state("reset");

    // Fill every slot (and probe overflow on the 8th character).
    load_str("T3", "++++++++", 0);
    walk("T3");
    run_op("T3.top", 1, 0, 0, 0, 0);
    run_op("T3.reload", 0, 0, 0, 1, 0);

    load_str("T1", "+[-].", 0);
    walk("T1");

    run_op("T4.rewind", 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) run_op("T4.inc", 1, 0, 0, 0, 0);
    run_op("T4.dec", 1, 1, 0, 0, 0);
    run_op("T4.rewind", 0, 0, 1, 0, 0);
    run_op("T4.dec0", 1, 1, 0, 0, 0);
    run_op("T4.junk", 0, 0, 0, 0, 1);

    run_op("T6.reload", 0, 0, 0, 1, 0);
    load_str("T6", "+[-].", 0);
    for (int i = 0; i < 4; i++) run_op("T6.inc", 1, 0, 0, 0, 0);
    do_reset("T6.reset");
    load_str("T6b", "+++++++++", 0);
    run_op("T6b.inc", 1, 0, 0, 0, 0);
    run_op("T6b.rw_ld", 1, 0, 1, 0, 0);
    run_op("T6b.dec0", 1, 1, 0, 0, 0);
    run_op("T6b.reload", 0, 0, 0, 1, 0);

    load_str("T2", "a+ b\n>", 0);
    walk("T2");
    run_op("T2.reload", 0, 0, 0, 1, 0);

    load_str("T5", "+.", 1);
    walk("T5");
    run_op("T5.reload", 0, 0, 0, 1, 0);

    load_str("EMPTY", "", 0);
    run_op("EMPTY.reload", 0, 0, 0, 1, 0);

    // Reset in the middle of a load abandons it.
    feed("MID", "+", 1'b1, 1'b0);
    do_reset("MID.reset");

    al = "<>+-[].,a \n";
    for (int it = 0; it < 25; it++) begin
      s = "";
      for (int k = 0; k < $urandom_range(0, 10); k++)
        s = {s, string'(al[$urandom_range(0, al.len() - 1)])};
      load_str("RND", s, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 15; k++)
        run_op("RND.run", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), 1'b0, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) do_reset("RND.reset");
      else run_op("RND.reload", 1'($urandom_range(0, 1)), 0,
                  1'($urandom_range(0, 1)), 1'b1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
